// File: rtl/reg_write_ctrl_pkg.sv
// rtl/reg_write_ctrl_pkg.sv - shared constants and decode helper for the register write-port controller
//
// Contents:
//   LATENCY_MIN / LATENCY_MAX : legal pipeline depth range
//   COMMIT_CNT_W              : width of the committed-write counter
//   onehot_bit()              : one bit of an enabled one-hot decode
package reg_write_ctrl_pkg;

  localparam int unsigned LATENCY_MIN  = 1;
  localparam int unsigned LATENCY_MAX  = 4;
  localparam int unsigned COMMIT_CNT_W = 16;

  // Bit 'pos' of onehot(idx) gated by en. Written per bit so the decoder
  // can be elaborated for any ADDR_W without a fixed-width return type.
  function automatic logic onehot_bit(input int unsigned idx,
                                      input int unsigned pos,
                                      input logic        en);
    return en && (idx == pos);
  endfunction

endpackage

// File: rtl/rwc_onehot_dec.sv
// rtl/rwc_onehot_dec.sv - ADDR_W to NUM_REGS one-hot decoder with enable
//
// Ports:
//   en_i   in  1         decode enable; output is all zero when low
//   idx_i  in  ADDR_W    index to decode
//   dec_o  out NUM_REGS  one-hot result, bit idx_i set when enabled
module rwc_onehot_dec
  import reg_write_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W   = 2,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   idx_i,
  output logic [NUM_REGS-1:0] dec_o
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign dec_o[i] = onehot_bit(32'(idx_i), i, en_i);
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - register-file write-port controller with pipeline and hazard tracking
//
// Optional feature macro: REG_WRITE_CTRL_ZERO_REG_EN (register 0 hardwired,
// writes to it are accepted and dropped).
//
// Ports:
//   clock       in  1            system clock, rising edge
//   reset       in  1            synchronous active-high reset
//   req_valid   in  1            write-back request present
//   req_ready   out 1            request can be accepted this cycle
//   req_rd      in  ADDR_W       destination register index
//   req_data    in  DATA_W       data to write
//   wb_ready    in  1            register file commits this cycle
//   flush       in  1            discard all in-flight writes
//   rs_a        in  ADDR_W       source index A for hazard check
//   rs_b        in  ADDR_W       source index B for hazard check
//   reg_we      out NUM_REGS     one-hot write enable
//   wr_data     out DATA_W       data accompanying reg_we
//   pending     out NUM_REGS     registers targeted by any valid stage
//   hazard_a    out 1            pending[rs_a]
//   hazard_b    out 1            pending[rs_b]
//   commit_cnt  out 16           committed writes, wraps
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W   = 2,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned LATENCY  = 1,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_rd,
  input  logic [DATA_W-1:0]       req_data,
  input  logic                    wb_ready,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       rs_a,
  input  logic [ADDR_W-1:0]       rs_b,
  output logic [NUM_REGS-1:0]     reg_we,
  output logic [DATA_W-1:0]       wr_data,
  output logic [NUM_REGS-1:0]     pending,
  output logic                    hazard_a,
  output logic                    hazard_b,
  output logic [COMMIT_CNT_W-1:0] commit_cnt
);

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
    $error("reg_write_ctrl: LATENCY must be within 1..4");
  end

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } stage_t;

  // Index 0 is the entry stage, LATENCY-1 drives the register file.
  stage_t                  stage_q [LATENCY];
  stage_t                  stage_d [LATENCY];
  logic [COMMIT_CNT_W-1:0] cnt_q;
  logic [COMMIT_CNT_W-1:0] cnt_d;

  logic                    valid_last;
  logic                    adv;
  logic                    accept;
  logic                    load_valid;
  logic                    commit;
  logic [NUM_REGS-1:0]     stage_dec [LATENCY];
  logic [NUM_REGS-1:0]     pending_w;

  assign valid_last = stage_q[LATENCY-1].valid;
  // An empty final stage never blocks; a full one moves only on commit.
  assign adv        = !valid_last || wb_ready;
  assign req_ready  = adv && !reset && !flush;
  assign accept     = req_valid && req_ready;
  assign commit     = valid_last && wb_ready;

`ifdef REG_WRITE_CTRL_ZERO_REG_EN
  // Writes to the hardwired zero register are consumed but enter as bubbles,
  // so they never reach reg_we, pending or the commit counter.
  assign load_valid = accept && (req_rd != '0);
`else
  assign load_valid = accept;
`endif

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      for (int s = 0; s < LATENCY; s++) begin
        stage_d[s].valid = 1'b0;
      end
    end else if (adv) begin
      stage_d[0].valid = load_valid;
      stage_d[0].rd    = req_rd;
      stage_d[0].data  = req_data;
      for (int s = 1; s < LATENCY; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  // A commit in a flush cycle still happened at the register file.
  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + COMMIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        stage_q[s].valid <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // One decoder per stage; the final stage's decode doubles as reg_we.
  for (genvar s = 0; s < LATENCY; s++) begin : g_stage_dec
    rwc_onehot_dec #(
      .ADDR_W (ADDR_W)
    ) u_dec (
      .en_i  (stage_q[s].valid),
      .idx_i (stage_q[s].rd),
      .dec_o (stage_dec[s])
    );
  end

  always_comb begin
    pending_w = '0;
    for (int s = 0; s < LATENCY; s++) begin
      pending_w = pending_w | stage_dec[s];
    end
  end

  assign reg_we     = stage_dec[LATENCY-1];
  assign wr_data    = stage_q[LATENCY-1].data;
  assign pending    = pending_w;
  assign hazard_a   = pending_w[rs_a];
  assign hazard_b   = pending_w[rs_b];
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb/tb_reg_write_ctrl.sv - directed and randomized bench for reg_write_ctrl against a queue model
module tb_reg_write_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int LAT    = 2;
  localparam int NREGS  = 4;

`ifdef REG_WRITE_CTRL_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rd;
  logic [DATA_W-1:0] req_data;
  logic              wb_ready;
  logic              flush;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rs_b;
  logic [NREGS-1:0]  reg_we;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  pending;
  logic              hazard_a;
  logic              hazard_b;
  logic [15:0]       commit_cnt;

  reg_write_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .wb_ready   (wb_ready),
    .flush      (flush),
    .rs_a       (rs_a),
    .rs_b       (rs_b),
    .reg_we     (reg_we),
    .wr_data    (wr_data),
    .pending    (pending),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
    .commit_cnt (commit_cnt)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Model: a fixed-length queue of slots, front = newest, back = writer.
  typedef struct {
    bit v;
    int rd;
    int data;
  } ent_t;

  ent_t pipe[$];
  int   exp_cnt;
  int   exp_we;
  int   exp_pend;
  bit   exp_adv;
  bit   exp_ready;
  bit   last_v;
  int   last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    ent_t last;
    last      = pipe[LAT-1];
    last_v    = last.v;
    last_data = last.data;
    exp_we    = last.v ? (1 << last.rd) : 0;
    exp_pend  = 0;
    foreach (pipe[i]) begin
      if (pipe[i].v) exp_pend = exp_pend | (1 << pipe[i].rd);
    end
    exp_adv   = !last.v || (wb_ready === 1'b1);
    exp_ready = exp_adv && (reset === 1'b0) && (flush === 1'b0);
  endtask

  task automatic tick_check();
    @(negedge clock);
    model_eval();
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("reg_we", 32'(reg_we), exp_we);
    if (last_v) chk("wr_data", 32'(wr_data), last_data);
    chk("pending", 32'(pending), exp_pend);
    chk("hazard_a", 32'(hazard_a), (exp_pend >> rs_a) & 1);
    chk("hazard_b", 32'(hazard_b), (exp_pend >> rs_b) & 1);
    chk("commit_cnt", 32'(commit_cnt), exp_cnt);
  endtask

  task automatic tick_edge();
    ent_t e;
    @(posedge clock);
    model_eval();
    if (reset) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
      exp_cnt = 0;
    end else begin
      if (last_v && wb_ready) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      if (flush) begin
        foreach (pipe[i]) pipe[i].v = 1'b0;
      end else if (exp_adv) begin
        e.v    = req_valid && exp_ready && !(ZERO_EN && (int'(req_rd) == 0));
        e.rd   = int'(req_rd);
        e.data = int'(req_data);
        void'(pipe.pop_back());
        pipe.push_front(e);
      end
    end
    #1;
  endtask

  task automatic cyc();
    tick_check();
    tick_edge();
  endtask

  task automatic drive(input bit v, input int rd, input int data);
    req_valid = v;
    req_rd    = ADDR_W'(rd);
    req_data  = DATA_W'(data);
  endtask

  initial begin
    ent_t e0;
    e0.v = 1'b0; e0.rd = 0; e0.data = 0;
    for (int i = 0; i < LAT; i++) pipe.push_back(e0);
    exp_cnt = 0;

    reset = 1'b1; wb_ready = 1'b1; flush = 1'b0; rs_a = '0; rs_b = '0;
    drive(1, 0, 0);
    @(posedge clock); #1;

    // Reset held with a request waiting.
    for (int i = 0; i < 2; i++) begin
      tick_check();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_we", 32'(reg_we), 0);
      chk("rst_pend", 32'(pending), 0);
      chk("rst_cnt", 32'(commit_cnt), 0);
      tick_edge();
    end

    // Streaming back-to-back.
    reset = 1'b0;
    drive(1, 3, 'h5A);
    tick_check(); chk("first_accept", 32'(req_ready), 1); tick_edge();
    drive(1, 1, 'hC3); cyc();
    drive(0, 0, 0);
    tick_check(); chk("stream_we0", 32'(reg_we), 'h8); chk("stream_wd0", 32'(wr_data), 'h5A); tick_edge();
    tick_check(); chk("stream_we1", 32'(reg_we), 'h2); chk("stream_wd1", 32'(wr_data), 'hC3); tick_edge();
    tick_check(); chk("stream_cnt", 32'(commit_cnt), 2); tick_edge();

    // Stall with rd=2 in the final stage.
    drive(1, 2, 'hAA); cyc();
    drive(1, 1, 'h33); cyc();
    wb_ready = 1'b0; drive(1, 3, 'h77);
    for (int i = 0; i < 3; i++) begin
      tick_check();
      chk("stall_we", 32'(reg_we), 'h4);
      chk("stall_wd", 32'(wr_data), 'hAA);
      chk("stall_ready", 32'(req_ready), 0);
      tick_edge();
    end
    wb_ready = 1'b1;
    tick_check(); chk("unstall_ready", 32'(req_ready), 1); tick_edge();
    drive(0, 0, 0);
    tick_check(); chk("unstall_we1", 32'(reg_we), 'h2); chk("unstall_wd1", 32'(wr_data), 'h33); tick_edge();
    tick_check(); chk("unstall_we2", 32'(reg_we), 'h8); chk("unstall_wd2", 32'(wr_data), 'h77); tick_edge();

    // Hazard tracking for rd=2.
    rs_a = 2'd2; rs_b = 2'd1;
    drive(1, 2, 'h05);
    tick_check(); chk("haz_pre", 32'(hazard_a), 0); tick_edge();
    drive(0, 0, 0);
    tick_check(); chk("haz_a_s1", 32'(hazard_a), 1); chk("haz_b_s1", 32'(hazard_b), 0); tick_edge();
    tick_check(); chk("haz_a_s2", 32'(hazard_a), 1); chk("haz_b_s2", 32'(hazard_b), 0); tick_edge();
    tick_check(); chk("haz_a_done", 32'(hazard_a), 0); tick_edge();

    // Flush with two writes in flight, no commit in the flush cycle.
    wb_ready = 1'b0;
    drive(1, 1, 'h10); cyc();
    drive(1, 2, 'h20); cyc();
    flush = 1'b1; drive(1, 3, 'h30);
    tick_check(); chk("flush_ready", 32'(req_ready), 0); chk("flush_cnt0", 32'(commit_cnt), 6); tick_edge();
    flush = 1'b0; wb_ready = 1'b1; drive(0, 0, 0);
    tick_check(); chk("flush_pend", 32'(pending), 0); chk("flush_we", 32'(reg_we), 0); chk("flush_cnt1", 32'(commit_cnt), 6); tick_edge();

    // Flush in a commit cycle: the commit still counts.
    drive(1, 1, 'h44); cyc();
    drive(1, 2, 'h55); cyc();
    flush = 1'b1; drive(0, 0, 0);
    tick_check(); chk("flushc_we", 32'(reg_we), 'h2); tick_edge();
    flush = 1'b0;
    tick_check(); chk("flushc_cnt", 32'(commit_cnt), 7); chk("flushc_pend", 32'(pending), 0); tick_edge();

    // Write to register 0.
    drive(1, 0, 'h42); cyc();
    drive(0, 0, 0);
    tick_check(); chk("zero_pend", 32'(pending) & 1, ZERO_EN ? 0 : 1); tick_edge();
    tick_check(); chk("zero_we", 32'(reg_we), ZERO_EN ? 0 : 1); tick_edge();
    tick_check(); chk("zero_cnt", 32'(commit_cnt), ZERO_EN ? 7 : 8); tick_edge();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      wb_ready  = ($urandom_range(0, 9) < 7);
      rs_a      = ADDR_W'($urandom_range(0, NREGS - 1));
      rs_b      = ADDR_W'($urandom_range(0, NREGS - 1));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, NREGS - 1), $urandom_range(0, 255));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
